// File: rtl/aer_in_arbiter.sv
// ---------------------------------------------------------------------------
// aer_in_arbiter
//
// Round-robin arbiter that merges N_SRC event sources onto a single
// four-phase AER input port of an SNN core. One event is taken per
// handshake: IDLE -> REQ_HI (REQ=1, wait for ACK) -> REQ_LO (REQ=0, wait
// for ACK to fall) -> IDLE.
//
// Parameters
//    N_SRC        number of event sources
//    ADDR_W       AER address width
//    TIMEOUT_CYC  ACK-rise watchdog limit in cycles (1..255)
//
// Ports
//    CLK          clock
//    RST          synchronous active-high reset
//    SRC_VALID    per-source event pending
//    SRC_ADDR     per-source address, source i at [i*ADDR_W +: ADDR_W]
//    SRC_READY    one-cycle pulse when a source's event is taken
//    AERIN_ADDR   address presented to the core (held through handshake)
//    AERIN_REQ    four-phase request
//    AERIN_ACK    four-phase acknowledge (asynchronous, synchronized here)
//    BUSY         high whenever a handshake is in progress
//    EVT_CNT      saturating count of acknowledged events
//    ERR_TIMEOUT  sticky ACK-timeout flag
//    ERR_CLR      clears ERR_TIMEOUT (a simultaneous new timeout wins)
//
// Build option
//    AER_ARB_TIMEOUT_EN  when defined, builds the ACK watchdog. When not
//                        defined, REQ_HI waits for ACK indefinitely and
//                        ERR_TIMEOUT is tied low.
// ---------------------------------------------------------------------------
module aer_in_arbiter #(
   parameter int N_SRC       = 4,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [N_SRC-1:0]          SRC_VALID,
   input  logic [N_SRC*ADDR_W-1:0]   SRC_ADDR,
   output logic [N_SRC-1:0]          SRC_READY,
   output logic [ADDR_W-1:0]         AERIN_ADDR,
   output logic                      AERIN_REQ,
   input  logic                      AERIN_ACK,
   output logic                      BUSY,
   output logic [15:0]               EVT_CNT,
   output logic                      ERR_TIMEOUT,
   input  logic                      ERR_CLR
);

   localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ_HI = 2'd1;
   localparam logic [1:0] ST_REQ_LO = 2'd2;

   logic [1:0]        r_state;
   logic [PTR_W-1:0]  r_ptr;
   logic              r_ack_meta;
   logic              r_ack_s;
   logic              r_req;
   logic [ADDR_W-1:0] r_addr;
   logic [N_SRC-1:0]  r_ready;
   logic [15:0]       r_evt_cnt;

   logic [ADDR_W-1:0] w_addr_arr [N_SRC];
   logic              w_any;
   logic [PTR_W-1:0]  w_grant;
   logic [PTR_W-1:0]  w_ptr_next;
   logic              w_timeout;

   // Unpack the flat address bus into one word per source.
   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_addr
         assign w_addr_arr[gi] = SRC_ADDR[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Two-flop synchronizer; nothing downstream looks at raw AERIN_ACK.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ack_meta <= 1'b0;
         r_ack_s    <= 1'b0;
      end else begin
         r_ack_meta <= AERIN_ACK;
         r_ack_s    <= r_ack_meta;
      end
   end

   // Round-robin pick: walk from the farthest offset down to the pointer so
   // the valid source closest to the pointer is the one left in w_grant.
   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (SRC_VALID[(int'(r_ptr) + k) % N_SRC]) begin
            w_any   = 1'b1;
            w_grant = PTR_W'((int'(r_ptr) + k) % N_SRC);
         end
      end
   end

   assign w_ptr_next = PTR_W'((int'(w_grant) + 1) % N_SRC);

`ifdef AER_ARB_TIMEOUT_EN
   logic [7:0] r_to_cnt;
   logic       r_err;

   // Counter sits at zero while idle, so it reads 0 in the first REQ_HI
   // cycle and equals the number of REQ_HI cycles already spent.
   assign w_timeout = (r_state == ST_REQ_HI) && !r_ack_s &&
                      (r_to_cnt == TIMEOUT_CYC[7:0]);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_to_cnt <= 8'd0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == ST_REQ_HI)
            r_to_cnt <= r_to_cnt + 8'd1;
         else
            r_to_cnt <= 8'd0;

         // A new timeout takes priority over a clear in the same cycle.
         if (w_timeout)
            r_err <= 1'b1;
         else if (ERR_CLR)
            r_err <= 1'b0;
      end
   end

   assign ERR_TIMEOUT = r_err;
`else
   logic w_unused;

   assign w_timeout   = 1'b0;
   assign ERR_TIMEOUT = 1'b0;
   assign w_unused    = ^{ERR_CLR, TIMEOUT_CYC[0]};
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_req     <= 1'b0;
         r_addr    <= '0;
         r_ready   <= '0;
         r_evt_cnt <= 16'd0;
      end else begin
         r_ready <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_REQ_HI;
                  r_req   <= 1'b1;
                  r_addr  <= w_addr_arr[w_grant];
                  r_ready <= N_SRC'(1) << w_grant;
                  r_ptr   <= w_ptr_next;
               end
            end
            ST_REQ_HI: begin
               if (r_ack_s) begin
                  r_req   <= 1'b0;
                  r_state <= ST_REQ_LO;
                  if (r_evt_cnt != 16'hFFFF)
                     r_evt_cnt <= r_evt_cnt + 16'd1;
               end else if (w_timeout) begin
                  // Abandon the event: drop REQ without counting it.
                  r_req   <= 1'b0;
                  r_state <= ST_REQ_LO;
               end
            end
            ST_REQ_LO: begin
               if (!r_ack_s)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign SRC_READY  = r_ready;
   assign AERIN_ADDR = r_addr;
   assign AERIN_REQ  = r_req;
   assign BUSY       = (r_state != ST_IDLE);
   assign EVT_CNT    = r_evt_cnt;

endmodule

// File: tb/tb_aer_in_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aer_in_arbiter
//
// Self-checking bench for aer_in_arbiter (N_SRC=4, ADDR_W=10,
// TIMEOUT_CYC=10). An ACK responder answers REQ a few cycles later in
// four-phase fashion. Expected grants, pointer and event count come from
// a transaction-level model kept here, plus a hand-written vector table.
// ---------------------------------------------------------------------------
module tb_aer_in_arbiter;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int TO = 10;

   logic          CLK = 1'b0;
   logic          RST;
   logic [N-1:0]  SRC_VALID;
   logic [N*AW-1:0] SRC_ADDR;
   logic [N-1:0]  SRC_READY;
   logic [AW-1:0] AERIN_ADDR;
   logic          AERIN_REQ;
   logic          AERIN_ACK = 1'b0;
   logic          BUSY;
   logic [15:0]   EVT_CNT;
   logic          ERR_TIMEOUT;
   logic          ERR_CLR;

   aer_in_arbiter #(
      .N_SRC       (N),
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .SRC_VALID   (SRC_VALID),
      .SRC_ADDR    (SRC_ADDR),
      .SRC_READY   (SRC_READY),
      .AERIN_ADDR  (AERIN_ADDR),
      .AERIN_REQ   (AERIN_REQ),
      .AERIN_ACK   (AERIN_ACK),
      .BUSY        (BUSY),
      .EVT_CNT     (EVT_CNT),
      .ERR_TIMEOUT (ERR_TIMEOUT),
      .ERR_CLR     (ERR_CLR)
   );

   always #5 CLK = ~CLK;

   int         n_pass  = 0;
   int         n_total = 0;
   int         m_ptr   = 0;
   int         m_cnt   = 0;
   logic [AW-1:0] src_addr [N];
   logic       ack_en  = 1'b1;
   logic [2:0] hist    = 3'b000;

   typedef struct {
      logic [N-1:0] valid;
      int           grant;
   } vec_t;
   vec_t tbl [15];

   // Four-phase responder: ACK follows REQ with a few cycles of delay.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         hist      = {hist[1:0], AERIN_REQ};
         AERIN_ACK = ack_en & hist[2];
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive_addrs();
      for (int i = 0; i < N; i++) SRC_ADDR[i*AW +: AW] = src_addr[i];
   endtask

   task automatic rand_addrs();
      for (int i = 0; i < N; i++) src_addr[i] = AW'($urandom);
      drive_addrs();
   endtask

   // Spec rule: first valid source at or after the pointer, wrapping.
   function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++)
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_taken(input int g, input bit acked);
      m_ptr = (g + 1) % N;
      if (acked && m_cnt < 65535) m_cnt++;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
   endtask

   // One full handshake. During it the sources and addresses are scrambled
   // to show they are not re-sampled; the held address must not move.
   task automatic do_hs(input logic [N-1:0] mask, input int exp_g, input string tag);
      logic [AW-1:0] exp_addr;
      bit done, extra, bad_addr;
      done = 0; extra = 0; bad_addr = 0;
      exp_addr  = src_addr[exp_g];
      SRC_VALID = mask;
      tick();
      check({tag, " ready"}, 32'(SRC_READY), 32'(1) << exp_g);
      check({tag, " req/addr"}, {21'd0, AERIN_REQ, AERIN_ADDR}, {21'd0, 1'b1, exp_addr});
      SRC_VALID = N'($urandom);
      rand_addrs();
      for (int n = 0; n < 60; n++) begin
         tick();
         if (SRC_READY != '0) extra = 1;
         if (BUSY && AERIN_ADDR !== exp_addr) bad_addr = 1;
         if (!BUSY) begin
            done = 1;
            break;
         end
      end
      SRC_VALID = '0;
      model_taken(exp_g, 1'b1);
      check({tag, " completed"}, 32'(done), 32'd1);
      check({tag, " extra ready"}, 32'(extra), 32'd0);
      check({tag, " addr stable"}, 32'(bad_addr), 32'd0);
      check({tag, " idle addr/req"}, {21'd0, AERIN_REQ, AERIN_ADDR}, {21'd0, 1'b0, exp_addr});
      check({tag, " evt_cnt"}, 32'(EVT_CNT), 32'(m_cnt));
      $display("hs %s: mask=%b grant=%0d addr=0x%0h evt_cnt=%0d", tag, mask, exp_g, exp_addr, EVT_CNT);
   endtask

   initial begin
      int n;
      bit done;
      logic [N-1:0] mask;

      tbl[0]  = '{4'b1111, 0}; tbl[1]  = '{4'b1111, 1};
      tbl[2]  = '{4'b1111, 2}; tbl[3]  = '{4'b1111, 3};
      tbl[4]  = '{4'b1111, 0}; tbl[5]  = '{4'b1111, 1};
      tbl[6]  = '{4'b1111, 2}; tbl[7]  = '{4'b1111, 3};
      tbl[8]  = '{4'b0001, 0}; tbl[9]  = '{4'b0010, 1};
      tbl[10] = '{4'b0011, 0}; tbl[11] = '{4'b0011, 1};
      tbl[12] = '{4'b1000, 3}; tbl[13] = '{4'b0110, 1};
      tbl[14] = '{4'b1001, 3};

      RST = 1'b1; SRC_VALID = '0; SRC_ADDR = '0; ERR_CLR = 1'b0;
      for (int i = 0; i < N; i++) src_addr[i] = '0;
      repeat (3) tick();
      check("reset req/addr", {21'd0, AERIN_REQ, AERIN_ADDR}, 32'd0);
      check("reset ready/busy", {27'd0, SRC_READY, BUSY}, 32'd0);
      check("reset evt_cnt", 32'(EVT_CNT), 32'd0);
      check("reset err", 32'(ERR_TIMEOUT), 32'd0);
      RST = 1'b0;
      tick();

      // Single source at address 0x155.
      src_addr[0] = 10'h155; src_addr[1] = 10'h0AA;
      src_addr[2] = 10'h3C3; src_addr[3] = 10'h01F;
      drive_addrs();
      do_hs(4'b0001, 0, "single");

      // Fairness and pointer-skip table from a fresh reset.
      pulse_reset();
      tick();
      for (int i = 0; i < 15; i++) begin
         rand_addrs();
         do_hs(tbl[i].valid, tbl[i].grant, $sformatf("tbl%0d", i));
      end
      check("tbl evt_cnt", 32'(EVT_CNT), 32'd15);

`ifdef AER_ARB_TIMEOUT_EN
      // Watchdog: ACK never answers.
      ack_en = 1'b0;
      rand_addrs();
      SRC_VALID = 4'b0001;
      tick();
      check("to ready", 32'(SRC_READY), 32'(1) << model_grant(4'b0001, m_ptr));
      model_taken(model_grant(4'b0001, m_ptr), 1'b0);
      SRC_VALID = '0;
      n = 0;
      done = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         n++;
         if (!AERIN_REQ) begin
            done = 1;
            break;
         end
      end
      check("to req dropped", 32'(done), 32'd1);
      check("to req high cycles", 32'(n), 32'(TO + 1));
      check("to err set", 32'(ERR_TIMEOUT), 32'd1);
      check("to evt_cnt", 32'(EVT_CNT), 32'(m_cnt));
      tick();
      check("to back idle", 32'(BUSY), 32'd0);
      repeat (3) tick();
      check("to err sticky", 32'(ERR_TIMEOUT), 32'd1);
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      check("to err cleared", 32'(ERR_TIMEOUT), 32'd0);
      $display("hs timeout: req high %0d cycles, evt_cnt=%0d", n, EVT_CNT);
      repeat (4) tick();
      ack_en = 1'b1;
`else
      // No watchdog: REQ must wait as long as ACK stays low.
      ack_en = 1'b0;
      rand_addrs();
      SRC_VALID = 4'b0001;
      tick();
      check("wait ready", 32'(SRC_READY), 32'(1) << model_grant(4'b0001, m_ptr));
      model_taken(model_grant(4'b0001, m_ptr), 1'b1);
      SRC_VALID = '0;
      repeat (30) tick();
      check("wait req/busy", {30'd0, AERIN_REQ, BUSY}, 32'd3);
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      check("wait err low", 32'(ERR_TIMEOUT), 32'd0);
      ack_en = 1'b1;
      done = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!BUSY) begin
            done = 1;
            break;
         end
      end
      check("wait completed", 32'(done), 32'd1);
      check("wait evt_cnt", 32'(EVT_CNT), 32'(m_cnt));
      $display("hs long wait: evt_cnt=%0d", EVT_CNT);
`endif

      // Randomized traffic checked against the model.
      for (int i = 0; i < 30; i++) begin
         mask = N'($urandom_range(0, 15));
         if (mask == '0) begin
            SRC_VALID = '0;
            repeat (3) tick();
            check($sformatf("rnd%0d idle", i), {27'd0, SRC_READY, BUSY}, 32'd0);
            $display("hs rnd%0d: no request, idle", i);
         end else begin
            rand_addrs();
            do_hs(mask, model_grant(mask, m_ptr), $sformatf("rnd%0d", i));
         end
      end

      // Reset in the middle of REQ_HI.
      rand_addrs();
      SRC_VALID = 4'b0010;
      tick();
      check("rstmid ready", 32'(SRC_READY), 32'b0010);
      SRC_VALID = '0;
      tick();
      tick();
      check("rstmid in req_hi", {30'd0, AERIN_REQ, BUSY}, 32'd3);
      RST = 1'b1;
      tick();
      check("rstmid req/busy", {30'd0, AERIN_REQ, BUSY}, 32'd0);
      check("rstmid evt_cnt", 32'(EVT_CNT), 32'd0);
      RST = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
      $display("hs rstmid: aborted by reset");
      repeat (8) tick();
      rand_addrs();
      do_hs(4'b1111, 0, "post-rst ptr0");
      rand_addrs();
      do_hs(4'b0100, 2, "post-rst src2");

      // Saturation from a preloaded count.
      force dut.r_evt_cnt = 16'hFFFE;
      tick();
      release dut.r_evt_cnt;
      tick();
      m_cnt = 65534;
      check("sat preload", 32'(EVT_CNT), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         rand_addrs();
         do_hs(4'b1111, model_grant(4'b1111, m_ptr), $sformatf("sat%0d", i));
      end
      check("sat final", 32'(EVT_CNT), 32'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
